// File: rtl/seq_multiply_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// The controller state type and the step-counter sizing helper live here so
// that the top level and any future wrappers agree on encodings.
package seq_multiply_pkg;

  // Legacy state encodings, kept as plain constants so older blocks that
  // compare raw two-bit codes keep working.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Controller states: waiting for operands, iterating, holding a result.
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } state_t;

  // Width of a counter that must be able to represent 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_multiply_dp.sv
// Datapath of the sequential multiplier: multiplicand register, the
// accumulator (upper product half), the multiplier shift register (which
// fills up with the lower product half) and the single WIDTH-bit adder.
// Optional two's-complement support is compiled in with
// SEQ_MULTIPLY_SIGNED_EN; without it the datapath is unsigned only.
module seq_multiply_dp
  import seq_multiply_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 finish,
  input  logic [WIDTH-1:0]     abus,
  input  logic [WIDTH-1:0]     bbus,
  output logic [2*WIDTH-1:0]   prod
`ifdef SEQ_MULTIPLY_SIGNED_EN
  ,
  input  logic                 sgn
`endif
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mult;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   mult_nxt;
  logic [2*WIDTH-1:0] raw_nxt;
  logic [2*WIDTH-1:0] final_nxt;

`ifdef SEQ_MULTIPLY_SIGNED_EN
  logic neg;
  logic neg_nxt;

  // Signed operands are reduced to magnitudes so the iteration itself is
  // always unsigned; the most negative value maps to its own bit pattern,
  // which read unsigned is exactly its magnitude.
  always_comb begin
    a_mag   = abus;
    b_mag   = bbus;
    neg_nxt = 1'b0;
    if (sgn) begin
      if (abus[WIDTH-1]) a_mag = ~abus + WIDTH'(1);
      if (bbus[WIDTH-1]) b_mag = ~bbus + WIDTH'(1);
      neg_nxt = abus[WIDTH-1] ^ bbus[WIDTH-1];
    end
  end

  // Remember whether the finished magnitude product must be negated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       neg <= 1'b0;
    else if (load) neg <= neg_nxt;
  end
`else
  // Unsigned build: operands go straight into the iteration.
  always_comb begin
    a_mag = abus;
    b_mag = bbus;
  end
`endif

  // One radix-2 step: conditionally add the multiplicand into the upper
  // half, then shift {carry, acc, mult} right by one. The bit leaving the
  // sum becomes the next product bit at the top of the multiplier register.
  always_comb begin
    addend    = mult[0] ? mcand : '0;
    sum       = {1'b0, acc} + {1'b0, addend};
    acc_nxt   = sum[WIDTH:1];
    mult_nxt  = {sum[0], mult[WIDTH-1:1]};
    raw_nxt   = {acc_nxt, mult_nxt};
`ifdef SEQ_MULTIPLY_SIGNED_EN
    final_nxt = neg ? (~raw_nxt + (2*WIDTH)'(1)) : raw_nxt;
`else
    final_nxt = raw_nxt;
`endif
  end

  // Operand capture and iteration registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      mult  <= '0;
    end else if (load) begin
      mcand <= a_mag;
      acc   <= '0;
      mult  <= b_mag;
    end else if (step) begin
      acc   <= acc_nxt;
      mult  <= mult_nxt;
    end
  end

  // The visible product only changes when the last step completes, so it
  // stays stable through DONE and keeps its value while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         prod <= '0;
    else if (finish) prod <= final_nxt;
  end

endmodule

// File: rtl/seq_multiply.sv
// Sequential WIDTH x WIDTH multiplier with valid/ready handshakes on both
// sides. Holds the IDLE/BUSY/DONE controller, the step counter and the
// handshake outputs; the arithmetic lives in seq_multiply_dp.
// Define SEQ_MULTIPLY_SIGNED_EN to add the sgn port and two's-complement
// operation.
module seq_multiply
  import seq_multiply_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     abus,
  input  logic [WIDTH-1:0]     bbus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out
`ifdef SEQ_MULTIPLY_SIGNED_EN
  ,
  input  logic                 sgn
`endif
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_step;
  logic          consume;

  // Handshake events derived from the current state.
  always_comb begin
    accept    = (state == IDLE) && in_valid;
    last_step = (state == BUSY) && (cnt == LAST);
    consume   = (state == DONE) && out_ready;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Next-state selection: always WIDTH busy cycles, and a consumed result
  // goes back to IDLE first so acceptance never overlaps consumption.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:    if (consume)   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Step counter: cleared on acceptance, advanced each busy cycle, parked
  // at zero outside BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                cnt <= '0;
    else if (accept || last_step)           cnt <= '0;
    else if (state == BUSY)                 cnt <= cnt + CW'(1);
  end

  seq_multiply_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (state == BUSY),
    .finish (last_step),
    .abus   (abus),
    .bbus   (bbus),
    .prod   (out)
`ifdef SEQ_MULTIPLY_SIGNED_EN
    ,
    .sgn    (sgn)
`endif
  );

endmodule

// File: tb/tb_seq_multiply.sv
// Self-checking bench for seq_multiply (WIDTH=8). Directed scenarios plus
// randomized operations, compared against an arithmetic reference product.
module tb_seq_multiply;

  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] abus;
  logic [WIDTH-1:0] bbus;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out;
  logic             sgn;

  int checks = 0;
  int errors = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  seq_multiply #(
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .abus      (abus),
    .bbus      (bbus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef SEQ_MULTIPLY_SIGNED_EN
    ,
    .sgn       (sgn)
`endif
  );

  // Reference product: plain multiplication of the (sign- or zero-)
  // extended operands, truncated to the product width.
  function automatic logic [PW-1:0] refMul(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic s);
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
`ifndef SEQ_MULTIPLY_SIGNED_EN
    s = 1'b0;
`endif
    if (s) begin
      ea = {{WIDTH{a[WIDTH-1]}}, a};
      eb = {{WIDTH{b[WIDTH-1]}}, b};
    end else begin
      ea = {{WIDTH{1'b0}}, a};
      eb = {{WIDTH{1'b0}}, b};
    end
    return ea * eb;
  endfunction

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for exactly one accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b,
                               input logic s);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput("accept_ready", in_ready, 1);
    abus     = a;
    bbus     = b;
    sgn      = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Full transaction: issue, measure latency, check product, optionally
  // hold off the consumer for 'hold' cycles, then consume.
  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic s, input int hold, input bit hasLit,
                       input logic [PW-1:0] lit);
    logic [PW-1:0] exp;
    logic [PW-1:0] held;
    int            n;
    exp       = refMul(a, b, s);
    out_ready = (hold == 0);
    applyStimulus(a, b, s);
    n = 0;
    while (!out_valid && n < 4 * WIDTH) begin
      checkOutput("busy_in_ready", in_ready, 0);
      tick();
      n++;
    end
    checkOutput("latency", n, WIDTH);
    checkOutput("product", out, exp);
    if (hasLit) checkOutput("product_lit", out, lit);
    held = out;
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
      checkOutput("hold_out", out, held);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("idle_out_valid", out_valid, 0);
    checkOutput("idle_in_ready", in_ready, 1);
    checkOutput("out_kept", out, held);
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [PW-1:0] expq[$];
    logic [PW-1:0] e;
    int            nacc;
    int            nres;
    int            lastAcc;
    int            seen;
    bit            accepted;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    abus      = '0;
    bbus      = '0;
    sgn       = 1'b0;

    // Reset state before any clock edge.
    #2;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out", out, 0);
    tick();
    rst = 1'b0;
    tick();

    // Directed boundary scenarios.
    runOp(8'hFF, 8'hFF, 1'b0, 0, 1'b1, 16'hFE01);
    runOp(8'h00, 8'hA5, 1'b0, 0, 1'b1, 16'h0000);
    runOp(8'h0C, 8'h0D, 1'b0, 5, 1'b1, 16'h009C);
    runOp(8'h80, 8'h80, 1'b0, 0, 1'b1, 16'h4000);
    runOp(8'h01, 8'hFF, 1'b0, 1, 1'b1, 16'h00FF);

    // Reset during BUSY discards the operation.
    abus     = 8'h12;
    bbus     = 8'h34;
    sgn      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_out", out, 0);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (out_valid) seen++;
      tick();
    end
    checkOutput("no_valid_after_rst", seen, 0);
    runOp(8'h03, 8'h05, 1'b0, 0, 1'b1, 16'h000F);

`ifdef SEQ_MULTIPLY_SIGNED_EN
    // Signed versus unsigned interpretation of the same bits.
    runOp(8'hFF, 8'h03, 1'b1, 0, 1'b1, 16'hFFFD);
    runOp(8'hFF, 8'h03, 1'b0, 0, 1'b1, 16'h02FD);
    runOp(8'h80, 8'h80, 1'b1, 1, 1'b1, 16'h4000);
    runOp(8'h80, 8'h7F, 1'b1, 0, 1'b1, 16'hC080);
`endif

    // in_valid held high across three operations.
    out_ready = 1'b1;
    abus      = WIDTH'($urandom);
    bbus      = WIDTH'($urandom);
    sgn       = 1'($urandom_range(0, 1));
    in_valid  = 1'b1;
    nacc      = 0;
    nres      = 0;
    lastAcc   = 0;
    for (int cyc = 0; cyc < 60 && (nacc < 3 || nres < 3); cyc++) begin
      accepted = 1'b0;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checkOutput("b2b_extra_result", 1, 0);
        end else begin
          e = expq.pop_front();
          checkOutput("b2b_product", out, e);
        end
        nres++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(refMul(abus, bbus, sgn));
        if (nacc > 0) checkOutput("b2b_spacing", cyc - lastAcc, WIDTH + 2);
        lastAcc  = cyc;
        nacc++;
        accepted = 1'b1;
      end
      tick();
      if (accepted) begin
        abus = WIDTH'($urandom);
        bbus = WIDTH'($urandom);
        sgn  = 1'($urandom_range(0, 1));
        if (nacc == 3) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checkOutput("b2b_accepts", nacc, 3);
    checkOutput("b2b_results", nres, 3);

    // Randomized operations with random consumer back-pressure.
    for (int k = 0; k < 20; k++) begin
      runOp(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)), 1'b0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
